// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: picks one result-broadcast requester per cycle and drives its tag/data onto the CDB.
// Define CDB_FIXED_PRIO_EN for lowest-index-wins priority; by default the grant is round-robin.
module cdb_arbiter #(
    parameter int NREQ  = 3,
    parameter int TAGW  = 5,
    parameter int DATAW = 32
) (
    input  logic                  clk,
    input  logic                  nRST,
    input  logic [NREQ-1:0]       Breq,
    input  logic [TAGW*NREQ-1:0]  LabelIn,
    input  logic [DATAW*NREQ-1:0] DataIn,
    output logic [NREQ-1:0]       BreqAC,
    output logic                  BCEN,
    output logic [TAGW-1:0]       BClabel,
    output logic [DATAW-1:0]      BCdata,
    output logic                  ProtoErr,
    output logic [15:0]           BcCount
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic            win_found;
    logic [PW-1:0]   win_idx;
    logic [NREQ-1:0] grant;
    logic [TAGW-1:0] win_label;
    logic [DATAW-1:0] win_data;

`ifdef CDB_FIXED_PRIO_EN
    // Descending scan so the lowest requesting index is the last one written.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (Breq[i]) begin
                win_found = 1'b1;
                win_idx   = PW'(i);
            end
        end
    end
`else
    logic [PW-1:0] ptr;

    always_comb begin
        int idx;
        idx       = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!win_found && Breq[idx]) begin
                win_found = 1'b1;
                win_idx   = PW'(idx);
            end
        end
    end

    // The pointer advances on every grant, including label-0 grants, so a bad requester is retired.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            ptr <= '0;
        end else if (win_found) begin
            ptr <= (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
        end
    end
`endif

    always_comb begin
        grant     = '0;
        win_label = '0;
        win_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (PW'(i) == win_idx) begin
                grant[i]  = win_found;
                win_label = LabelIn[i*TAGW +: TAGW];
                win_data  = DataIn[i*DATAW +: DATAW];
            end
        end
    end

    assign BreqAC = nRST ? grant : '0;

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            BCEN     <= 1'b0;
            BClabel  <= '0;
            BCdata   <= '0;
            ProtoErr <= 1'b0;
            BcCount  <= '0;
        end else if (win_found) begin
            if (win_label != '0) begin
                BCEN    <= 1'b1;
                BClabel <= win_label;
                BCdata  <= win_data;
                BcCount <= BcCount + 16'd1;
            end else begin
                // Label 0 would look like "no tag" to the stations: drop it and flag the requester.
                BCEN     <= 1'b0;
                ProtoErr <= 1'b1;
            end
        end else begin
            BCEN <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: directed test-plan cases plus randomized held requests,
// checked against a reference model of the grant rules.
module tb_cdb_arbiter;

    localparam int NREQ  = 3;
    localparam int TAGW  = 5;
    localparam int DATAW = 32;
    localparam int EW    = 2 + 16 + TAGW + DATAW;

    logic                  clk;
    logic                  nRST;
    logic [NREQ-1:0]       Breq;
    logic [TAGW*NREQ-1:0]  LabelIn;
    logic [DATAW*NREQ-1:0] DataIn;
    logic [NREQ-1:0]       BreqAC;
    logic                  BCEN;
    logic [TAGW-1:0]       BClabel;
    logic [DATAW-1:0]      BCdata;
    logic                  ProtoErr;
    logic [15:0]           BcCount;

    cdb_arbiter #(.NREQ(NREQ), .TAGW(TAGW), .DATAW(DATAW)) dut (
        .clk(clk), .nRST(nRST), .Breq(Breq), .LabelIn(LabelIn), .DataIn(DataIn),
        .BreqAC(BreqAC), .BCEN(BCEN), .BClabel(BClabel), .BCdata(BCdata),
        .ProtoErr(ProtoErr), .BcCount(BcCount)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard: one entry per cycle {bcen, protoerr, count, label, data}
    logic [EW-1:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;
    logic mon_en = 1'b0;

    // Reference model state
    int          m_ptr;
    logic        m_perr;
    int          m_cnt;
    logic [TAGW-1:0]  m_label;
    logic [DATAW-1:0] m_data;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr   = 0;
        m_perr  = 1'b0;
        m_cnt   = 0;
        m_label = '0;
        m_data  = '0;
    endtask

    // Winner by the grant rule: scan from the pointer upward with wrap, or lowest index in fixed mode.
    function automatic int model_winner(input logic [NREQ-1:0] b);
`ifdef CDB_FIXED_PRIO_EN
        for (int i = 0; i < NREQ; i++) if (b[i]) return i;
`else
        for (int k = 0; k < NREQ; k++) if (b[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
`endif
        return -1;
    endfunction

    // Driver: called at a negedge; applies inputs, checks the combinational grant, pushes the expectation.
    task automatic drive_cycle(input logic [NREQ-1:0] b, input logic [TAGW*NREQ-1:0] lab,
                               input logic [DATAW*NREQ-1:0] dat, output int w);
        logic bcen;
        logic [NREQ-1:0] exp_ac;
        Breq = b; LabelIn = lab; DataIn = dat;
        #1;
        w = model_winner(b);
        exp_ac = '0;
        bcen = 1'b0;
        if (w >= 0) begin
            exp_ac[w] = 1'b1;
            if (lab[w*TAGW +: TAGW] == 0) begin
                m_perr = 1'b1;
            end else begin
                bcen    = 1'b1;
                m_cnt   = (m_cnt + 1) % 65536;
                m_label = lab[w*TAGW +: TAGW];
                m_data  = dat[w*DATAW +: DATAW];
            end
            m_ptr = (w + 1) % NREQ;
        end
        check("breqac", 64'(BreqAC), 64'(exp_ac));
        exp_q.push_back({bcen, m_perr, 16'(m_cnt), m_label, m_data});
    endtask

    function automatic logic [TAGW*NREQ-1:0] labs(input int l0, input int l1, input int l2);
        return {TAGW'(l2), TAGW'(l1), TAGW'(l0)};
    endfunction

    function automatic logic [DATAW*NREQ-1:0] dats(input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2);
        return {d2, d1, d0};
    endfunction

    // Monitor: pops one expectation per clock and compares the registered CDB outputs.
    initial begin
        logic [EW-1:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                if (exp_q.size() == 0) begin
                    check("sb_underflow", 64'(1), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("bcen", 64'(BCEN), 64'(e[EW-1]));
                    check("protoerr", 64'(ProtoErr), 64'(e[EW-2]));
                    check("bccount", 64'(BcCount), 64'(e[EW-3 -: 16]));
                    if (e[EW-1]) begin
                        check("bclabel", 64'(BClabel), 64'(e[DATAW +: TAGW]));
                        check("bcdata", 64'(BCdata), 64'(e[DATAW-1:0]));
                    end
                end
            end
        end
    end

    // Main stimulus
    initial begin
        int w;
        logic [NREQ-1:0] pend;
        logic [TAGW-1:0] plab [NREQ];
        logic [DATAW-1:0] pdat [NREQ];
        logic [TAGW*NREQ-1:0] lv;
        logic [DATAW*NREQ-1:0] dv;

        nRST = 1'b0; Breq = '0; LabelIn = '0; DataIn = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_bcen", 64'(BCEN), 64'(0));
        check("rst_label", 64'(BClabel), 64'(0));
        check("rst_data", 64'(BCdata), 64'(0));
        check("rst_perr", 64'(ProtoErr), 64'(0));
        check("rst_count", 64'(BcCount), 64'(0));

        // Simultaneous requests from reset, then single request, pointer wrap, fixed-prio pattern
        @(negedge clk); nRST = 1'b1; mon_en = 1'b1;
        drive_cycle(3'b111, labs(1, 9, 17), dats(32'h1111_0000, 32'h2222_0000, 32'h3333_0000), w);
        repeat (5) begin
            @(negedge clk);
            drive_cycle(3'b111, labs(1, 9, 17), dats(32'h1111_0000, 32'h2222_0000, 32'h3333_0000), w);
        end
        @(negedge clk); drive_cycle(3'b000, labs(0, 0, 0), dats(0, 0, 0), w);
        @(negedge clk); drive_cycle(3'b010, labs(0, 9, 0), dats(0, 32'hDEAD_BEEF, 0), w);
        @(negedge clk); drive_cycle(3'b100, labs(0, 0, 20), dats(0, 0, 32'hCAFE_0002), w);
        @(negedge clk); drive_cycle(3'b101, labs(3, 0, 21), dats(32'hA0, 0, 32'hA2), w);
        @(negedge clk); drive_cycle(3'b101, labs(3, 0, 21), dats(32'hA0, 0, 32'hA2), w);
        repeat (3) begin
            @(negedge clk); drive_cycle(3'b110, labs(0, 12, 13), dats(0, 32'hB1, 32'hB2), w);
        end
        // Label zero, then legal broadcasts keep ProtoErr set
        @(negedge clk); drive_cycle(3'b001, labs(0, 0, 0), dats(32'h5A5A, 0, 0), w);
        @(negedge clk); drive_cycle(3'b000, labs(0, 0, 0), dats(0, 0, 0), w);
        @(negedge clk); drive_cycle(3'b010, labs(0, 7, 0), dats(0, 32'h77, 0), w);
        @(negedge clk); drive_cycle(3'b001, labs(6, 0, 0), dats(32'h66, 0, 0), w);

        // Randomized held requests with occasional drops and label-0 requesters
        pend = '0;
        for (int c = 0; c < 400; c++) begin
            for (int g = 0; g < NREQ; g++) begin
                if (!pend[g] && $urandom_range(0, 2) == 0) begin
                    pend[g] = 1'b1;
                    plab[g] = ($urandom_range(0, 15) == 0) ? '0 : TAGW'($urandom_range(1, 31));
                    pdat[g] = $urandom;
                end else if (pend[g] && $urandom_range(0, 19) == 0) begin
                    pend[g] = 1'b0;
                end
            end
            for (int g = 0; g < NREQ; g++) begin
                lv[g*TAGW +: TAGW]   = pend[g] ? plab[g] : TAGW'($urandom);
                dv[g*DATAW +: DATAW] = pend[g] ? pdat[g] : $urandom;
            end
            @(negedge clk);
            drive_cycle(pend, lv, dv, w);
            if (w >= 0) pend[w] = 1'b0;
        end

        // Reset while broadcasting
        @(negedge clk); drive_cycle(3'b111, labs(4, 5, 6), dats(32'hC0, 32'hC1, 32'hC2), w);
        @(posedge clk);
        #3;
        mon_en = 1'b0;
        nRST = 1'b0;
        #1;
        check("midrst_bcen", 64'(BCEN), 64'(0));
        check("midrst_label", 64'(BClabel), 64'(0));
        check("midrst_data", 64'(BCdata), 64'(0));
        check("midrst_breqac", 64'(BreqAC), 64'(0));
        check("midrst_count", 64'(BcCount), 64'(0));
        check("midrst_perr", 64'(ProtoErr), 64'(0));
        exp_q.delete();
        model_reset();
        Breq = '0;
        @(negedge clk);
        nRST = 1'b1; mon_en = 1'b1;
        drive_cycle(3'b111, labs(4, 5, 6), dats(32'hC0, 32'hC1, 32'hC2), w);
        check("post_rst_winner", 64'(w), 64'(0));
        @(negedge clk); drive_cycle(3'b111, labs(4, 5, 6), dats(32'hC0, 32'hC1, 32'hC2), w);
        @(negedge clk); drive_cycle(3'b000, labs(0, 0, 0), dats(0, 0, 0), w);

        // Drain
        @(posedge clk);
        #2;
        check("sb_drained", 64'(exp_q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
